sysid_check_ctrl: RTL and testbench
===================================

# sysid_check_ctrl

Boot-time sequencer for the system-ID slave. It masters the slave's two-word read port: word 0 holds the system ID and word 1 holds the build timestamp. It reads both words, compares them against the IDs expected at build time, and reports the result on status pins and on a small Avalon-MM status slave for the CPU. It sits between the sysid slave and the Qsys interconnect, so firmware or board logic can refuse to run on a mismatched FPGA image.

## Interface
- EXPECTED_ID, 1278338, expected word 0.
- EXPECTED_TS, 1345812261, expected word 1.
- TIMEOUT_CYCLES, 255, maximum cycles per read transaction (1..65535).
- AUTO_START, 1, start a check automatically after reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m_address  out  1  word select to the sysid slave.
- m_read  out  1  read request.
- m_waitrequest  in  1  request stall; tie 0 for a zero-wait slave.
- m_readdata  in  32  read data.
- m_readdatavalid  in  1  data valid; tie 1 for a combinational slave.
- s_address  in  2  status register select.
- s_read  in  1  status read; zero wait, combinational readdata.
- s_readdata  out  32  status read data.
- s_write  in  1  status write.
- s_writedata  in  32  status write data.
- done  out  1  check finished (pass, fail or timeout).
- pass  out  1  done and both words matched.

## Operation
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE.
- IDLE:
  - Go to REQ_ID if AUTO_START is 1 on the first edge after reset.
  - Otherwise go to REQ_ID on a restart command.
- REQ_x:
  - Drive m_read=1 and m_address (0 for ID, 1 for TS).
  - Hold both until m_waitrequest=0 is sampled, then go to WAIT_x.
- WAIT_x:
  - m_read=0; m_address is held at the same value.
  - On m_readdatavalid=1, capture m_readdata into cap_x and set x_ok = (m_readdata == EXPECTED_x).
  - WAIT_ID then goes to REQ_TS; WAIT_TS goes to DONE.
- Timeout:
  - A 16-bit counter clears on entry to REQ_x and increments every cycle spent in REQ_x or WAIT_x.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: drop m_read, set timeout=1, go to DONE.
  - The unread word's ok flag stays 0.
  - A late m_readdatavalid arriving in DONE or IDLE is ignored.
- DONE:
  - done=1; pass = id_ok & ts_ok & ~timeout.
  - Stays in DONE until a restart command.
- Restart command: s_write=1 with s_address=0 and s_writedata[0]=1.
  - Honoured only in IDLE or DONE; ignored while busy.
  - Clears id_ok, ts_ok, timeout, cap_id and cap_ts, and moves to REQ_ID on the next edge.
- Status map (s_readdata is combinational from s_address):
  - Address 0: bit0 busy (state not IDLE/DONE), bit1 done, bit2 id_ok, bit3 ts_ok, bit4 timeout, other bits 0.
  - Address 1: cap_id. Address 2: cap_ts. Address 3: {16'b0, timeout counter}.
  - Writes to addresses 1-3 are ignored.
- Simultaneous s_write restart and s_read of address 0 return the pre-restart value.

## Timing
- Reset:
  - State IDLE; m_read=0, m_address=0.
  - done=0, pass=0; flags, captures and counter all 0.
  - Asserting reset mid-transaction aborts immediately, with no completion.
- Edges are numbered from the first rising edge with reset_n high. With a zero-wait slave and readdatavalid tied 1 (AUTO_START=1):
  - Edge 1: to REQ_ID; m_read=1, m_address=0.
  - Edge 2: to WAIT_ID.
  - Edge 3: capture ID; to REQ_TS.
  - Edge 4: to WAIT_TS.
  - Edge 5: capture TS; to DONE. done and pass are valid after edge 5.
- Each cycle of m_waitrequest=1 in REQ_x adds one cycle. Each cycle of m_readdatavalid=0 in WAIT_x adds one cycle.
- A timeout transition happens on the edge where the counter equals TIMEOUT_CYCLES-1.
- Restart accepted at edge N: state is REQ_ID after edge N and done=0; done=1 again after edge N+4 (zero-wait case).

## Test plan
- Reset release, sysid slave attached (1278338 / 1345812261): done=1 and pass=1 after edge 5; status address 0 reads 0x0E; address 1 reads 1278338; address 2 reads 1345812261.
- Word 1 returns 0x50000000: done=1, pass=0, status address 0 reads 0x06, address 2 reads 0x50000000.
- m_waitrequest held 1 for 3 cycles on each request: m_read held with a stable address throughout; done after edge 11; pass=1.
- m_readdatavalid never asserted, TIMEOUT_CYCLES=8: m_read drops and DONE is reached on edge 8; status 0x12; a late readdatavalid leaves cap_id at 0.
- Restart write while busy (at edge 2): ignored and the sequence finishes normally. Restart written in DONE: flags clear, busy=1 on the next read, pass=1 again 4 edges later.
- reset_n asserted during WAIT_TS: all outputs zero immediately. Release with AUTO_START=0: stays IDLE, m_read=0, until a restart is written.

Source files
------------

// File: rtl/sysid_check_ctrl_if.sv
// sysid_check_ctrl_if: two-word Avalon-MM read port between the checker (master) and the sysid slave.
interface sysid_check_ctrl_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    modport master(output address, read, input waitrequest, readdata, readdatavalid);
    modport slave(input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads sysid word 0/1, compares against build-time IDs, reports on pins and a status slave.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1278338,
    parameter logic [31:0] EXPECTED_TS    = 32'd1345812261,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    sysid_check_ctrl_if.master m,
    input  logic [1:0]         s_address,
    input  logic               s_read,
    output logic [31:0]        s_readdata,
    input  logic               s_write,
    input  logic [31:0]        s_writedata,
    output logic               done,
    output logic               pass
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ_ID  = 3'd1;
    localparam logic [2:0] WAIT_ID = 3'd2;
    localparam logic [2:0] REQ_TS  = 3'd3;
    localparam logic [2:0] WAIT_TS = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [15:0] LIMIT  = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] cnt, cnt_inc;
    logic [31:0] cap_id, cap_ts;
    logic        id_ok, ts_ok, timeout, arm;
    logic        busy, is_req, is_wait, got, expire, restart, unused_bits;

    always_comb begin
        busy        = state != IDLE && state != DONE;
        is_req      = state == REQ_ID || state == REQ_TS;
        is_wait     = state == WAIT_ID || state == WAIT_TS;
        got         = is_wait && m.readdatavalid;
        cnt_inc     = cnt + 16'd1;
        expire      = cnt_inc >= LIMIT;
        restart     = !busy && s_write && s_address == 2'd0 && s_writedata[0];
        unused_bits = s_read ^ (^s_writedata[31:1]);
        s_readdata  = s_address == 2'd0 ? {27'd0, timeout, ts_ok, id_ok, done, busy} :
                      s_address == 2'd1 ? cap_id :
                      s_address == 2'd2 ? cap_ts : {16'd0, cnt};
    end

    assign m.read    = is_req;
    assign m.address = state == REQ_TS || state == WAIT_TS;
    assign done      = state == DONE;
    assign pass      = done && id_ok && ts_ok && !timeout;

    // arm is high only for the first edge after reset, giving the one-shot auto start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cap_id  <= '0;
            cap_ts  <= '0;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
            arm     <= 1'b1;
        end else begin
            arm <= 1'b0;
            if (!busy) begin
                if (restart || (arm && AUTO_START)) begin
                    state   <= REQ_ID;
                    cnt     <= '0;
                    cap_id  <= '0;
                    cap_ts  <= '0;
                    id_ok   <= 1'b0;
                    ts_ok   <= 1'b0;
                    timeout <= 1'b0;
                end
            end else begin
                cnt <= cnt_inc;
                if (got && state == WAIT_ID) begin
                    cap_id <= m.readdata;
                    id_ok  <= m.readdata == EXPECTED_ID;
                    state  <= REQ_TS;
                    cnt    <= '0;
                end else if (got) begin
                    cap_ts <= m.readdata;
                    ts_ok  <= m.readdata == EXPECTED_TS;
                    state  <= DONE;
                end else if (expire) begin
                    timeout <= 1'b1;
                    state   <= DONE;
                end else if (is_req && !m.waitrequest) begin
                    state <= state + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed table-driven bench; DUT a = defaults, DUT b = TIMEOUT 8, no auto start.
module tb_sysid_check_ctrl;
    localparam logic [31:0] ID = 32'd1278338;
    localparam logic [31:0] TS = 32'd1345812261;

    typedef struct {
        int          ed;
        logic [1:0]  sa;
        logic [31:0] st;
        logic        rd;
        logic        ad;
        logic        dn;
        logic        ps;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sa_addr = '0, sb_addr = '0;
    logic        sa_write = 1'b0, sb_write = 1'b0;
    logic [31:0] sa_wdata = '0, sb_wdata = '0;
    logic [31:0] sa_rdata, sb_rdata;
    logic        done_a, pass_a, done_b, pass_b;
    logic [31:0] ts_word = TS;
    logic        wr_mode = 1'b0, rdv_b = 1'b0;
    int          wcnt = 0;
    int          checks = 0, errors = 0;
    vec_t        tbl[7];

    sysid_check_ctrl_if ia();
    sysid_check_ctrl_if ib();

    assign ia.readdata      = ia.address ? ts_word : ID;
    assign ia.waitrequest   = wr_mode && ia.read && wcnt < 3;
    assign ia.readdatavalid = 1'b1;
    assign ib.readdata      = ib.address ? TS : ID;
    assign ib.waitrequest   = 1'b0;
    assign ib.readdatavalid = rdv_b;

    always #10 clock = ~clock;
    always @(posedge clock) wcnt <= ia.read ? wcnt + 1 : 0;

    sysid_check_ctrl dut_a (
        .clock(clock), .reset_n(reset_n), .m(ia),
        .s_address(sa_addr), .s_read(1'b1), .s_readdata(sa_rdata),
        .s_write(sa_write), .s_writedata(sa_wdata),
        .done(done_a), .pass(pass_a)
    );

    sysid_check_ctrl #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .m(ib),
        .s_address(sb_addr), .s_read(1'b1), .s_readdata(sb_rdata),
        .s_write(sb_write), .s_writedata(sb_wdata),
        .done(done_b), .pass(pass_b)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic restart_a();
        sa_addr = 2'd0; sa_wdata = 32'd1; sa_write = 1'b1;
        tick();
        sa_write = 1'b0;
    endtask

    task automatic restart_b();
        sb_addr = 2'd0; sb_wdata = 32'd1; sb_write = 1'b1;
        tick();
        sb_write = 1'b0;
    endtask

    initial begin
        int edge_n;
        tbl = '{
            '{1, 2'd0, 32'h01, 1'b1, 1'b0, 1'b0, 1'b0},
            '{2, 2'd0, 32'h01, 1'b0, 1'b0, 1'b0, 1'b0},
            '{3, 2'd0, 32'h05, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4, 2'd0, 32'h05, 1'b0, 1'b1, 1'b0, 1'b0},
            '{5, 2'd0, 32'h0E, 1'b0, 1'b0, 1'b1, 1'b1},
            '{5, 2'd1, ID,     1'b0, 1'b0, 1'b1, 1'b1},
            '{5, 2'd2, TS,     1'b0, 1'b0, 1'b1, 1'b1}
        };

        // reset state
        tick(); tick();
        check("rst_read", 32'(ia.read), 0);
        check("rst_addr", 32'(ia.address), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_status", sa_rdata, 0);
        reset_n = 1'b1;
        edge_n = 0;

        // zero-wait boot check, edge by edge
        for (int i = 0; i < 7; i++) begin
            while (edge_n < tbl[i].ed) begin
                tick();
                edge_n++;
            end
            sa_addr = tbl[i].sa;
            #1;
            check($sformatf("vec%0d_status", i), sa_rdata, tbl[i].st);
            check($sformatf("vec%0d_read", i), 32'(ia.read), 32'(tbl[i].rd));
            check($sformatf("vec%0d_addr", i), 32'(ia.address), 32'(tbl[i].ad));
            check($sformatf("vec%0d_done", i), 32'(done_a), 32'(tbl[i].dn));
            check($sformatf("vec%0d_pass", i), 32'(pass_a), 32'(tbl[i].ps));
        end
        check("b_idle_read", 32'(ib.read), 0);
        check("b_idle_status", sb_rdata, 0);

        // wrong timestamp; restart read in the same cycle returns the old status
        ts_word = 32'h5000_0000;
        sa_addr = 2'd0; sa_wdata = 32'd1; sa_write = 1'b1;
        #1;
        check("simul_read_status", sa_rdata, 32'h0E);
        tick();
        sa_write = 1'b0;
        #1;
        check("restart_busy", sa_rdata, 32'h01);
        check("restart_done", 32'(done_a), 0);
        repeat (3) tick();
        check("badts_done_early", 32'(done_a), 0);
        tick();
        check("badts_done", 32'(done_a), 1);
        check("badts_pass", 32'(pass_a), 0);
        check("badts_status", sa_rdata, 32'h06);
        sa_addr = 2'd2; #1;
        check("badts_cap_ts", sa_rdata, 32'h5000_0000);

        // restart while busy is ignored
        ts_word = TS;
        restart_a();
        restart_a();
        repeat (2) tick();
        check("busy_restart_done_early", 32'(done_a), 0);
        tick();
        check("busy_restart_done", 32'(done_a), 1);
        check("busy_restart_pass", 32'(pass_a), 1);
        check("busy_restart_status", sa_rdata, 32'h0E);

        // three wait-request cycles on each request
        wr_mode = 1'b1;
        restart_a();
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) tick();
            check($sformatf("wr%0d_read", k), 32'(ia.read), 32'((k < 4) || (k >= 5 && k < 9)));
            check($sformatf("wr%0d_addr", k), 32'(ia.address), 32'(k >= 5 && k < 10));
            check($sformatf("wr%0d_done", k), 32'(done_a), 32'(k == 10));
        end
        check("wr_pass", 32'(pass_a), 1);
        wr_mode = 1'b0;

        // asynchronous reset during WAIT_TS
        restart_a();
        repeat (3) tick();
        check("wts_addr", 32'(ia.address), 1);
        #3;
        reset_n = 1'b0;
        #1;
        sa_addr = 2'd0; #1;
        check("abort_read", 32'(ia.read), 0);
        check("abort_addr", 32'(ia.address), 0);
        check("abort_done", 32'(done_a), 0);
        check("abort_pass", 32'(pass_a), 0);
        check("abort_status", sa_rdata, 0);
        sa_addr = 2'd1; #1;
        check("abort_cap_id", sa_rdata, 0);
        tick();
        reset_n = 1'b1;

        // no auto start on b, then a timeout with TIMEOUT_CYCLES=8
        repeat (6) tick();
        check("noauto_read", 32'(ib.read), 0);
        check("noauto_status", sb_rdata, 0);
        restart_b();
        check("to_req_read", 32'(ib.read), 1);
        tick();
        check("to_wait_read", 32'(ib.read), 0);
        repeat (5) tick();
        check("to_done_early", 32'(done_b), 0);
        tick();
        check("to_done", 32'(done_b), 1);
        check("to_pass", 32'(pass_b), 0);
        check("to_read", 32'(ib.read), 0);
        check("to_status", sb_rdata, 32'h12);
        rdv_b = 1'b1;
        tick();
        rdv_b = 1'b0;
        check("late_status", sb_rdata, 32'h12);
        sb_addr = 2'd1; #1;
        check("late_cap_id", sb_rdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
